// File: rtl/bj_msg_pkg.sv
// Shared constants for the message scroller: message ids, ROM contents, FSM states.
// Pure declarations plus one ROM lookup helper; no timing of its own.
// Not applicable (no handshake lives here).
package bj_msg_pkg;

  localparam int MAX_LEN  = 16;
  localparam int NUM_MSGS = 4;
  localparam int LEN_W    = $clog2(MAX_LEN + 1);
  localparam int POS_W    = $clog2(MAX_LEN);
  localparam int SEL_W    = $clog2(NUM_MSGS);

  localparam logic [SEL_W-1:0] MSG_WIN  = 2'd0;
  localparam logic [SEL_W-1:0] MSG_LOSE = 2'd1;
  localparam logic [SEL_W-1:0] MSG_BUST = 2'd2;
  localparam logic [SEL_W-1:0] MSG_PUSH = 2'd3;

  // One row per message; character k lives in nibble k (bits [4k+3:4k]).
  localparam logic [MAX_LEN*4-1:0] CODES_WIN  = 64'h0000_0000_0000_0321;
  localparam logic [MAX_LEN*4-1:0] CODES_LOSE = 64'h0000_0000_0000_7654;
  localparam logic [MAX_LEN*4-1:0] CODES_BUST = 64'h0000_0000_0000_BA98;
  localparam logic [MAX_LEN*4-1:0] CODES_PUSH = 64'h0000_0000_0000_FEDC;

  // Packed so that element [id] selects the row for message id.
  localparam logic [NUM_MSGS-1:0][MAX_LEN*4-1:0] MSG_ROM =
    {CODES_PUSH, CODES_BUST, CODES_LOSE, CODES_WIN};

  localparam logic [NUM_MSGS-1:0][LEN_W-1:0] MSG_LEN =
    {LEN_W'(4), LEN_W'(4), LEN_W'(4), LEN_W'(3)};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scroll_state_e;

  // Character code at position pos of message id; positions past the ROM row read as 0.
  function automatic logic [3:0] msg_char(input logic [SEL_W-1:0] id,
                                          input logic [LEN_W-1:0] pos);
    logic [MAX_LEN*4-1:0] row;
    row      = MSG_ROM[id];
    msg_char = 4'h0;
    if (pos < LEN_W'(MAX_LEN)) begin
      msg_char = row[{pos[POS_W-1:0], 2'b00} +: 4];
    end
  endfunction

endpackage

// File: rtl/bj_msg_scroller_tick_gen.sv
// Step strobe generator: tick is high for one cycle every TICK_DIV cycles.
// tick asserts combinationally while the counter sits at TICK_DIV-1; clear restarts the count at 0.
// No backpressure; the strobe free-runs and the consumer ignores it when not scrolling.
module tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Next count: restart on clear or on wrap, otherwise advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bj_msg_scroller.sv
// Scrolls a stored game message right-to-left across NUM_DIGITS character decoders.
// Display shifts one step every TICK_DIV cycles; busy rises on the edge that accepts start.
// start is ignored while busy; stop aborts on the next edge; done pulses once on normal completion.
module bj_msg_scroller
  import bj_msg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop,
  input  logic [1:0]              msg_sel,
  output logic [4*NUM_DIGITS-1:0] char_out,
  output logic [NUM_DIGITS-1:0]   blank_n,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = $clog2(MAX_LEN + NUM_DIGITS + 1);

  scroll_state_e           state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    loop_q, loop_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] char_q, char_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic                    done_q, done_d;

  logic             tick;
  logic             tick_clear;
  logic             start_ok;
  logic [IDX_W-1:0] last_idx;
  logic             new_vis;
  logic [3:0]       new_code;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  // Empty messages are never started; stop always beats a simultaneous start.
  assign start_ok = start && !stop && (MSG_LEN[msg_sel] != '0);

  // Index of the final shift of a pass: message length plus the trailing blanks, minus one.
  assign last_idx = IDX_W'(len_q) + IDX_W'(NUM_DIGITS - 1);

  // Character entering digit 0: message text first, then blanks (code 0) past the end.
  assign new_vis  = (idx_q < IDX_W'(len_q));
  assign new_code = new_vis ? msg_char(sel_q, LEN_W'(idx_q)) : 4'h0;

  // Next-state, shift and handshake logic.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    loop_d     = loop_q;
    len_d      = len_q;
    idx_d      = idx_q;
    char_d     = char_q;
    blank_d    = blank_q;
    done_d     = 1'b0;
    tick_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        char_d  = '0;
        blank_d = '0;
        if (start_ok) begin
          state_d    = ST_RUN;
          sel_d      = msg_sel;
          loop_d     = loop;
          len_d      = MSG_LEN[msg_sel];
          idx_d      = '0;
          tick_clear = 1'b1;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          char_d  = '0;
          blank_d = '0;
          idx_d   = '0;
        end else if (tick) begin
          char_d  = {char_q[4*NUM_DIGITS-5:0], new_code};
          blank_d = {blank_q[NUM_DIGITS-2:0], new_vis};
          if (idx_q == last_idx) begin
            // Last shift of a pass leaves the display fully dark.
            idx_d = '0;
            if (!loop_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        char_d  = '0;
        blank_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      loop_q  <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      char_q  <= '0;
      blank_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      loop_q  <= loop_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      blank_q <= blank_d;
      done_q  <= done_d;
    end
  end

  assign char_out = char_q;
  assign blank_n  = blank_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_bj_msg_scroller.sv
// Self-checking bench for bj_msg_scroller with a scaled-down step period.
// Outputs are compared 1 time unit after every rising edge against a reference model.
// Reference tracks only elapsed edges since start and derives the display arithmetically.
module tb_bj_msg_scroller;

  localparam int ND = 6;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          reset, start, stop, loop;
  logic [1:0]    msg_sel;
  logic [4*ND-1:0] char_out;
  logic [ND-1:0] blank_n;
  logic          busy, done;

  int n_vec = 0;
  int n_err = 0;

  bj_msg_scroller #(
    .NUM_DIGITS(ND),
    .TICK_DIV  (TD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .msg_sel (msg_sel),
    .char_out(char_out),
    .blank_n (blank_n),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Reference message table.
  int ref_len [4]    = '{3, 4, 4, 4};
  int ref_msg [4][4] = '{'{1, 2, 3, 0}, '{4, 5, 6, 7}, '{8, 9, 10, 11}, '{12, 13, 14, 15}};

  // Reference state: scrolling flag, edges elapsed since start, latched message and loop flag.
  bit m_busy = 0;
  bit m_loop = 0;
  bit m_done = 0;
  int m_sel  = 0;
  int m_e    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the reference by one clock edge given the inputs sampled at that edge.
  task automatic model_edge(input bit r, input bit s, input bit p, input bit l, input logic [1:0] sel);
    m_done = 0;
    if (r) begin
      m_busy = 0;
    end else if (m_busy) begin
      if (p) begin
        m_busy = 0;
      end else begin
        m_e++;
        if (!m_loop && m_e == TD * (ref_len[m_sel] + ND)) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (s && !p && ref_len[sel] != 0) begin
      m_busy = 1;
      m_e    = 0;
      m_sel  = int'(sel);
      m_loop = l;
    end
  endtask

  // After m steps, digit k shows stream position (t-1-k) of the current pass.
  task automatic check_outputs();
    logic [4*ND-1:0] exp_char;
    logic [ND-1:0]   exp_bl;
    int m, t, p, s_len;
    exp_char = '0;
    exp_bl   = '0;
    if (m_busy) begin
      s_len = ref_len[m_sel] + ND;
      m     = m_e / TD;
      if (m > 0) begin
        t = ((m - 1) % s_len) + 1;
        for (int k = 0; k < ND; k++) begin
          p = t - 1 - k;
          if (p >= 0 && p < ref_len[m_sel]) begin
            exp_bl[k]         = 1'b1;
            exp_char[4*k +: 4] = 4'(ref_msg[m_sel][p]);
          end
        end
      end
    end
    chk("char_out", 32'(char_out), 32'(exp_char));
    chk("blank_n",  32'(blank_n),  32'(exp_bl));
    chk("busy",     32'(busy),     32'(m_busy));
    chk("done",     32'(done),     32'(m_done));
  endtask

  task automatic step(input bit r, input bit s, input bit p, input bit l, input logic [1:0] sel);
    reset   = r;
    start   = s;
    stop    = p;
    loop    = l;
    msg_sel = sel;
    @(posedge clk);
    model_edge(r, s, p, l, sel);
    #1;
    check_outputs();
  endtask

  // Quiet cycles with random loop/msg_sel, which must be ignored without start.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 1'($urandom), 2'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; msg_sel = 2'd0;

    // Reset state.
    step(1, 0, 0, 0, 2'd0);
    step(1, 0, 0, 0, 2'd0);
    idle(2);

    // Normal WIN scroll to completion and beyond.
    step(0, 1, 0, 0, 2'd0);
    idle(42);

    // LOSE looping past the first pass, then stop.
    step(0, 1, 0, 1, 2'd1);
    idle(47);
    step(0, 0, 1, 0, 2'd1);
    idle(6);

    // BUST stopped mid-scroll.
    step(0, 1, 0, 0, 2'd2);
    idle(8);
    step(0, 0, 1, 0, 2'd2);
    idle(3);
    step(0, 0, 1, 0, 2'd2);

    // Start while busy (different id and loop) must not disturb the scroll.
    step(0, 1, 0, 0, 2'd2);
    idle(3);
    step(0, 1, 0, 1, 2'd3);
    idle(5);
    step(0, 1, 0, 1, 2'd3);
    idle(36);

    // Start and stop together in IDLE.
    step(0, 1, 1, 0, 2'd3);
    idle(3);

    // Reset mid-scroll, then a fresh scroll.
    step(0, 1, 0, 0, 2'd3);
    idle(13);
    step(1, 0, 0, 0, 2'd3);
    step(0, 1, 0, 0, 2'd3);
    idle(42);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 300) == 0, ($urandom % 6) == 0, ($urandom % 60) == 0,
           1'($urandom), 2'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bj_msg_scroller.md
Name: bj_msg_scroller

Overview:
- Upstream feeder for the per-digit character decoders: produces NUM_DIGITS 4-bit character codes plus a per-digit blank mask, scrolling a stored game message ("WIN", "LOSE", "BUST", "PUSH") right-to-left across the 7-segment bank.
- Each char_out nibble drives one decoder instance directly; blank_n gates that digit's segment drive at the top level.
- Controlled by the blackjack game FSM through a start/stop/done handshake.

Parameters:
- NUM_DIGITS, 6, number of display digits driven.
- TICK_DIV, 25000000, clock cycles per scroll step (0.5 s at 50 MHz); legal range >=2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin scrolling message msg_sel.
- stop  input  1  abort the current scroll immediately.
- loop  input  1  sampled with start; 1 = repeat the message until stop.
- msg_sel  input  2  message id (package constant).
- char_out  output  4*NUM_DIGITS  character codes; digit 0 (rightmost) = [3:0].
- blank_n  output  NUM_DIGITS  1 = digit shows its char_out; 0 = digit dark.
- busy  output  1  high while scrolling.
- done  output  1  one-cycle pulse at normal (non-loop) completion.

Behaviour:
- Reset: state IDLE; char_out=0, blank_n=0, busy=0, done=0, tick counter=0, index=0. Reset mid-scroll yields the same values on the next edge; no done pulse.
- States: IDLE, RUN.
- IDLE: display fully blank. When start=1 and stop=0 at edge N, latch msg_sel, loop, msg length L. Clear tick counter and index. Enter RUN. busy=1 from edge N.
- Virtual stream: msg[0..L-1] followed by NUM_DIGITS blanks; total S=L+NUM_DIGITS steps.
- RUN: tick counter counts 0..TICK_DIV-1. On the wrap edge, perform one shift:
  - digit k takes digit k-1 (code and blank bit) for k>=1;
  - digit 0 takes stream[index] (blank_n[0]=0 and code 0 when index>=L);
  - index increments.
  - First shift lands at edge N+TICK_DIV; step j at edge N+j*TICK_DIV.
- Completion is the edge that performs shift S (display now fully dark):
  - loop=0: go IDLE, busy=0 and done=1 for exactly one cycle.
  - loop=1: index restarts at 0, no done pulse; next step shows msg[0] at digit 0.
- Blank digits always carry char_out nibble 0.
- stop=1 in RUN: next edge goes IDLE; all digits blank, busy=0, no done pulse. stop in IDLE has no effect.
- start while busy is ignored, including msg_sel and loop changes. start and stop in the same cycle: stop wins.
- msg_sel naming an entry of length 0: start is ignored and the block stays IDLE.
- Counters: tick counter width clog2(TICK_DIV); index width clog2(MAX_LEN+NUM_DIGITS+1).

Decomposition:
- Package bj_msg_pkg holds:
  - MAX_LEN=16, NUM_MSGS=4;
  - ids MSG_WIN=0, MSG_LOSE=1, MSG_BUST=2, MSG_PUSH=3;
  - message ROM as code arrays plus length table. Contents: WIN={1,2,3} L=3; LOSE={4,5,6,7} L=4; BUST={8,9,10,11} L=4; PUSH={12,13,14,15} L=4.
- Sub-module tick_gen (parameter TICK_DIV; inputs clk, reset, clear; output tick) provides the step strobe. clear is asserted on start acceptance.

Test Plan (NUM_DIGITS=6, TICK_DIV=4):
- Reset: assert reset 2 cycles -> char_out=0, blank_n=000000, busy=0, done=0.
- Normal scroll: start at cycle 0 with msg_sel=0, loop=0 ->
  - busy=1 at cycle 1;
  - cycle 4: digit0=1, blank_n=000001;
  - cycle 8: digit1=1, digit0=2, blank_n=000011;
  - cycle 12: digits2..0=1,2,3, blank_n=000111;
  - cycle 36: blank_n=000000, done=1 for one cycle, busy=0.
- Loop: start with msg_sel=1, loop=1 -> no done at step 10; step 11 shows digit0=4; stop asserted -> all dark and busy=0 next edge, done never pulses.
- Stop mid-scroll: start with msg_sel=2, stop at cycle 9 -> cycle 10 blank_n=000000, busy=0, done=0.
- Start collisions: start while busy with msg_sel=3 -> scroll continues showing codes 8..11; start+stop same cycle in IDLE -> remains IDLE.
- Reset at cycle 14 mid-scroll -> all outputs 0 next edge; new start scrolls from msg[0].
